// File: rtl/fetch_instruction_memory_pkg.sv
// Shared ISA constants and the fetch result type used by the instruction fetch memory.
package fetch_instruction_memory_pkg;

  localparam int          ISA_LEN_ADDRESS     = 32;
  localparam int          ISA_LEN_INSTRUCTION = 32;
  localparam logic [31:0] ISA_NOP_WORD        = 32'hE000_0000;

  typedef struct packed {
    logic                           fault;
    logic [ISA_LEN_INSTRUCTION-1:0] instruction;
  } fetch_word_t;

endpackage

// File: rtl/fetch_instruction_memory_byte_bank.sv
// Byte-addressed instruction store: one byte write port, one big-endian word read port.
module instruction_byte_bank
  import fetch_instruction_memory_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] NOP_WORD    = ISA_NOP_WORD,
  localparam int         IDXW        = $clog2(DEPTH_WORDS)
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [IDXW+1:0]                waddr,
  input  logic [7:0]                     wdata,
  input  logic [IDXW-1:0]                raddr,
  output logic [ISA_LEN_INSTRUCTION-1:0] rdata
);

  // Lane l holds byte offset l of every word; lane 0 lands in bits 31:24.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS] = '{default: NOP_WORD[31-8*l -: 8]};

    always_ff @(posedge clk) begin
      if (we && waddr[1:0] == 2'(l))
        mem[waddr[IDXW+1:2]] <= wdata;
    end

    assign rdata[31-8*l -: 8] = mem[raddr];
  end

endmodule

// File: rtl/fetch_instruction_memory.sv
// Instruction fetch memory: valid/ready fetch port with one-entry response register, fault detection and byte program load.
module fetch_instruction_memory
  import fetch_instruction_memory_pkg::*;
#(
  parameter int          LEN_ADDRESS = ISA_LEN_ADDRESS,
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] NOP_WORD    = ISA_NOP_WORD
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [LEN_ADDRESS-1:0]         req_addr,
  input  logic                           flush,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ISA_LEN_INSTRUCTION-1:0] rsp_instruction,
  output logic [LEN_ADDRESS-1:0]         rsp_addr,
  output logic                           rsp_fault,
  input  logic                           load_en,
  input  logic [LEN_ADDRESS-1:0]         load_addr,
  input  logic [7:0]                     load_byte
);

  localparam int IDXW = $clog2(DEPTH_WORDS);

  logic                           accept;
  logic                           req_oor;
  logic                           load_oor;
  logic [ISA_LEN_INSTRUCTION-1:0] rd_word;
  fetch_word_t                    fw;

  assign req_ready = (!rsp_valid || rsp_ready) && !flush;
  assign accept    = req_valid && req_ready;

  // Any address bit above the byte index means out of range; the index never wraps.
  assign req_oor  = (req_addr  >> (IDXW + 2)) != '0;
  assign load_oor = (load_addr >> (IDXW + 2)) != '0;

  instruction_byte_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .NOP_WORD    (NOP_WORD)
  ) u_bank (
    .clk   (clk),
    .we    (load_en && !load_oor),
    .waddr (load_addr[IDXW+1:0]),
    .wdata (load_byte),
    .raddr (req_addr[IDXW+1:2]),
    .rdata (rd_word)
  );

  always_comb begin
    fw.fault       = (req_addr[1:0] != 2'b00) || req_oor;
    fw.instruction = fw.fault ? NOP_WORD : rd_word;
  end

  // The bank read is combinational, so registering it here captures pre-write data on a same-word load.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid       <= 1'b0;
      rsp_instruction <= NOP_WORD;
      rsp_addr        <= '0;
      rsp_fault       <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (accept) begin
      rsp_valid       <= 1'b1;
      rsp_instruction <= fw.instruction;
      rsp_addr        <= req_addr;
      rsp_fault       <= fw.fault;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_instruction_memory.sv
// Scoreboard bench: a byte-array reference model queues expected responses; a monitor checks the DUT every cycle.
module tb_fetch_instruction_memory;

  localparam int          DEPTH = 64;
  localparam int          NBYTE = DEPTH * 4;
  localparam logic [31:0] NOP   = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_fault;
  logic [31:0] rsp_instruction, rsp_addr;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [7:0]  load_byte = '0;

  fetch_instruction_memory #(.LEN_ADDRESS(32), .DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instruction(rsp_instruction),
    .rsp_addr(rsp_addr), .rsp_fault(rsp_fault), .load_en(load_en), .load_addr(load_addr),
    .load_byte(load_byte)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] instr; logic fault; } exp_t;

  int   nchk = 0, nfail = 0;
  bit   mon_en = 1'b0;
  logic [7:0] mem [NBYTE];
  exp_t q[$];
  bit   m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_fetch(input logic [31:0] a);
    exp_t e;
    e.addr  = a;
    e.fault = (a % 4 != 0) || (a >= NBYTE);
    e.instr = e.fault ? NOP : {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    return e;
  endfunction

  initial for (int i = 0; i < NBYTE; i++) mem[i] = (i % 4 == 0) ? 8'hE0 : 8'h00;

  // Reference model: evaluates the handshake from the driven inputs, reads before applying the load.
  always @(posedge clk) begin
    if (rst || flush) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      bit acc;
      acc = req_valid && (!m_valid || rsp_ready);
      if (m_valid && rsp_ready) begin
        void'(q.pop_front());
        m_valid = 1'b0;
      end
      if (acc) begin
        q.push_back(expect_fetch(req_addr));
        m_valid = 1'b1;
      end
    end
    if (load_en && load_addr < NBYTE) mem[load_addr] = load_byte;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, (!m_valid || rsp_ready) && !flush});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
      if (m_valid && rsp_valid) begin
        if (q.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
        else begin
          chk("rsp_addr", rsp_addr, q[0].addr);
          chk("rsp_instruction", rsp_instruction, q[0].instr);
          chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, q[0].fault});
        end
      end
    end
  end

  task automatic cyc(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                     input logic le, input logic [31:0] la, input logic [7:0] lb, input logic r);
    req_valid = rv; req_addr = ra; rsp_ready = rr; flush = fl;
    load_en = le; load_addr = la; load_byte = lb; rst = r;
    @(posedge clk); #2;
  endtask

  task automatic fetch(input logic [31:0] a, input logic rr);
    cyc(1'b1, a, rr, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [7:0] b);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a, b, 1'b0);
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
  endtask

  logic [7:0] prog [4] = '{8'hE3, 8'hA0, 8'h00, 8'h14};

  initial begin
    cyc(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1);
    cyc(1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 32'h0, 8'h0, 1'b1);
    chk("reset_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_instr", rsp_instruction, NOP);
    chk("reset_addr", rsp_addr, 32'h0);
    chk("reset_fault", {31'b0, rsp_fault}, 32'd0);
    idle(1'b1);
    mon_en = 1'b1;

    // Program load and first fetch
    for (int i = 0; i < 4; i++) load(i, prog[i]);
    fetch(32'h0, 1'b1);
    chk("load_fetch_instr", rsp_instruction, 32'hE3A0_0014);
    chk("load_fetch_fault", {31'b0, rsp_fault}, 32'd0);
    idle(1'b1);

    // Back-to-back fetches with a two-cycle consumer stall
    fetch(32'h0, 1'b0);
    fetch(32'h4, 1'b0);
    chk("stall_ready", {31'b0, req_ready}, 32'd0);
    fetch(32'h4, 1'b0);
    chk("stall_hold", rsp_addr, 32'h0);
    fetch(32'h4, 1'b1);
    chk("stall_next", rsp_addr, 32'h4);
    fetch(32'h8, 1'b1);
    chk("stall_last", rsp_addr, 32'h8);
    idle(1'b1);
    chk("stall_drain", {31'b0, rsp_valid}, 32'd0);

    // Misaligned and out-of-range fetches
    fetch(32'h6, 1'b1);
    chk("misalign_fault", {31'b0, rsp_fault}, 32'd1);
    chk("misalign_instr", rsp_instruction, NOP);
    fetch(32'h100, 1'b1);
    chk("oor_fault", {31'b0, rsp_fault}, 32'd1);
    chk("oor_instr", rsp_instruction, NOP);
    idle(1'b1);

    // Same-cycle fetch and load to one word reads old contents
    cyc(1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 32'h4, 8'hFF, 1'b0);
    chk("rbw_old", rsp_instruction, 32'hE000_0000);
    fetch(32'h4, 1'b1);
    chk("rbw_new", rsp_instruction, 32'hFF00_0000);
    idle(1'b1);

    // Flush while a response is held and a request is pending
    fetch(32'h8, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0);
    chk("flush_valid", {31'b0, rsp_valid}, 32'd0);
    idle(1'b1);

    // Reset (with flush) during a stall leaves storage intact
    fetch(32'h4, 1'b0);
    fetch(32'h8, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 8'h0, 1'b1);
    chk("rst_stall_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_stall_instr", rsp_instruction, NOP);
    fetch(32'h0, 1'b1);
    chk("rst_keep_data", rsp_instruction, 32'hE3A0_0014);
    idle(1'b1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ra, la;
      int sel;
      sel = $urandom_range(0, 9);
      ra  = (sel < 7) ? ($urandom_range(0, DEPTH - 1) * 4) :
            (sel < 9) ? $urandom_range(0, NBYTE - 1) : $urandom_range(NBYTE, NBYTE * 4);
      la  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, NBYTE - 1) : (NBYTE + $urandom_range(0, 255));
      cyc($urandom_range(0, 3) != 0, ra, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 2) == 0, la, 8'($urandom), $urandom_range(0, 49) == 0);
    end
    idle(1'b1);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/fetch_instruction_memory.md
FETCH_INSTRUCTION_MEMORY -- requirements
Module: fetch_instruction_memory

Interface
REQ-001 Parameter LEN_ADDRESS, default 32, byte-address width.
REQ-002 Parameter DEPTH_WORDS, default 64, number of 32-bit instruction words stored (power of two, >= 4).
REQ-003 Parameter NOP_WORD, default 32'hE000_0000, power-up fill and fault/idle output value.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_ready  output  1  block accepts a fetch this cycle.
REQ-008 req_addr  input  LEN_ADDRESS  byte address of the fetch.
REQ-009 flush  input  1  discard the held response and any same-cycle request.
REQ-010 rsp_valid  output  1  response held in the output register.
REQ-011 rsp_ready  input  1  consumer takes the response this cycle.
REQ-012 rsp_instruction  output  32  fetched word.
REQ-013 rsp_addr  output  LEN_ADDRESS  req_addr of the held response.
REQ-014 rsp_fault  output  1  held response is misaligned or out of range.
REQ-015 load_en  input  1  program-load byte write strobe.
REQ-016 load_addr  input  LEN_ADDRESS  byte address of the load write.
REQ-017 load_byte  input  8  byte to write.

Function
REQ-018 Storage shall be byte-addressed, DEPTH_WORDS*4 bytes; a word is assembled big-endian: byte at {word,2'b00} occupies bits 31:24 and byte at {word,2'b11} occupies bits 7:0.
REQ-019 req_ready shall equal (!rsp_valid || rsp_ready) && !flush, combinationally.
REQ-020 A fetch is accepted when req_valid && req_ready; the response shall appear one cycle later (rsp_valid=1, rsp_addr=req_addr).
REQ-021 rsp_valid, rsp_instruction, rsp_addr and rsp_fault shall hold stable while rsp_valid && !rsp_ready && !flush.
REQ-022 Response consumed (rsp_valid && rsp_ready) with no new accept shall clear rsp_valid next cycle; with a new accept, back-to-back throughput of one fetch per cycle shall be sustained.
REQ-023 req_addr[1:0] != 0 shall set rsp_fault=1 and return NOP_WORD.
REQ-024 req_addr >= DEPTH_WORDS*4 shall set rsp_fault=1 and return NOP_WORD; no wrap-around of the index.
REQ-025 flush=1 shall clear rsp_valid at the next edge, regardless of rsp_ready or req_valid.
REQ-026 load_en=1 with load_addr in range shall write load_byte at the next edge; out-of-range load writes shall be ignored.
REQ-027 Fetch and load to the same word in the same cycle: the response shall carry the pre-write contents (read-before-write).
REQ-028 Load writes shall never stall fetches and never change a response already held.

Reset
REQ-029 With rst=1 at an edge: rsp_valid=0, rsp_instruction=NOP_WORD, rsp_addr=0, rsp_fault=0; any same-cycle request shall be dropped.
REQ-030 rst shall not alter storage contents; storage shall be NOP_WORD in every word at power-up.
REQ-031 rst and flush asserted together shall behave as rst.

Structure
REQ-032 LEN_ADDRESS, LEN_INSTRUCTION (32) and NOP_WORD default shall live in the shared ISA.v include.
REQ-033 Byte storage shall be a sub-module instruction_byte_bank (one write port, one word-wide read port); handshake and fault logic stay in the top.

Verification
REQ-034 Load bytes E3,A0,00,14 at 0x00..0x03, fetch 0x00 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_instruction=32'hE3A00014, rsp_fault=0.
REQ-035 Fetch 0x00,0x04,0x08 on consecutive cycles, rsp_ready held 0 for 2 cycles after first response -> req_ready=0 while stalled, response 0x00 stable, then 0x04, 0x08 each delivered exactly once.
REQ-036 Fetch 0x06, then fetch 0x100 with DEPTH_WORDS=64 -> each rsp_fault=1, rsp_instruction=32'hE0000000.
REQ-037 Same-cycle fetch 0x04 and load 0xFF at 0x04 (old word 32'hE0000000) -> response 32'hE0000000; next fetch 0x04 -> 32'hFF000000.
REQ-038 Response held with rsp_ready=0, flush=1 with req_valid=1 -> next cycle rsp_valid=0, request not accepted.
REQ-039 rst=1 mid-stall after loads -> rsp_valid=0, rsp_instruction=32'hE0000000; subsequent fetch returns loaded data unchanged.
